vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator: next generation of the fixed 640x480 `vga_sync` block. It derives the pixel strobe from the system clock, runs horizontal/vertical counters over programmable porch/sync/active widths, and produces sync pulses of selectable polarity. It also produces `video_on`, pixel coordinates, a clock-enable gate and line/frame start strobes. It sits between the system clock domain and the pixel/character renderers feeding the VGA DAC.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal front porch, sync, back porch (pixels)
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical front porch, sync, back porch (lines)
- `CLK_DIV`, 2: system clocks per pixel (>=1)
- `HS_POL`, 0 / `VS_POL`, 0: asserted level of hsync/vsync
- `CW`, 10: counter/coordinate width
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `en`  in  1  run enable; 0 freezes all timing
- `hsync`  out  1  horizontal sync, level per `HS_POL`
- `vsync`  out  1  vertical sync, level per `VS_POL`
- `video_on`  out  1  current pixel is in the active area
- `p_tick`  out  1  one-clk strobe: new pixel coordinate valid this cycle
- `pixel_x`  out  CW  horizontal count
- `pixel_y`  out  CW  vertical count
- `line_start`  out  1  one-clk strobe when `pixel_x` becomes 0
- `frame_start`  out  1  one-clk strobe when (`pixel_x`,`pixel_y`) becomes (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Default H_TOTAL is 800 and V_TOTAL is 525.
- Internal tick = `en` && div_cnt==CLK_DIV-1. div_cnt counts 0..CLK_DIV-1 while `en`=1 and holds while `en`=0.
- On tick, h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments. v_cnt wraps from V_TOTAL-1 to 0.
- hsync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. vsync is asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. Outside these ranges each is at its inactive level.
- `video_on` = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
- `pixel_x`/`pixel_y` are h_cnt/v_cnt. All outputs are registered and computed from next-state counts, so syncs, `video_on` and coordinates change on the same edge.
- `en`=0: counters, div_cnt and all levels hold. `p_tick`, `line_start` and `frame_start` are 0.
- CLK_DIV=1: `p_tick` is continuously 1 while `en`=1.
- Elaboration error if CLK_DIV<1, any width is 0, or H_TOTAL/V_TOTAL > 2**CW.

## Timing
- Reset values (asynchronous, immediate):
  - div_cnt, h_cnt, v_cnt, `pixel_x`, `pixel_y` = 0
  - `p_tick`, `line_start`, `frame_start`, `video_on` = 0
  - `hsync` = ~HS_POL, `vsync` = ~VS_POL
- First clk edge after reset release:
  - `video_on`=1, because (0,0) is active.
  - No start strobes are issued for the reset position. The first `frame_start` comes at the first full-frame wrap.
- `p_tick` is high in the first clk cycle in which the new coordinate is presented. Latency from tick to new coordinate is 1 clk.
- `line_start` = `p_tick` && `pixel_x`==0. `frame_start` additionally requires `pixel_y`==0. Both occur in the same cycle as their `p_tick`.
- Line period is H_TOTAL*CLK_DIV enabled clks. Frame period is H_TOTAL*V_TOTAL*CLK_DIV enabled clks.
- Reset asserted mid-frame returns the block to the reset values immediately. Release resumes from (0,0).
- `en` deasserted mid-line: the position is held exactly. On re-enable, the remaining div count completes before the next tick.

## Structure
- Package `vga_timing_pkg`: default 640x480@60 constants, a 800x600 set, and a `total(active,fp,sync,bp)` function.
- Sub-module `pixel_tick_gen`: the CLK_DIV divider with `en`, producing the internal tick.
- Counters, decode and output registers live in `vga_timing_gen`.

## Test plan
- Defaults, `en`=1:
  - `hsync`=0 exactly for `pixel_x` 656..751, each pixel lasting 2 clks.
  - `vsync`=0 for `pixel_y` 490..491.
  - `frame_start` period is 840000 clks.
- Defaults:
  - `video_on`=1 iff x<640 and y<480.
  - `pixel_x` goes from 799 to 0 with `line_start`=1 and `pixel_y` incrementing.
  - y goes from 524 to 0 with `frame_start`=1.
- CLK_DIV=1, H=4/1/2/1, V=3/1/1/1, HS_POL=VS_POL=1:
  - `p_tick` is constantly 1 and the line period is 8 clks.
  - `hsync`=1 at x=5..6 and `vsync`=1 at y=4.
- Drop `en` for 37 clks at (100,20): all outputs hold, strobes are 0, and the sequence resumes with no skipped or duplicated pixel.
- Assert `reset` between clk edges at (700,300):
  - Outputs reach their reset values without waiting for a clk edge.
  - After release, counting restarts at (0,0) and the first `frame_start` occurs 840000 clks later.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster constants and helpers for the VGA timing generator.
package vga_timing_pkg;

    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;

    function automatic int total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick_gen.sv
// Divides the system clock into a one-clk pixel tick; the divider freezes while en is low.
module pixel_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);

    logic [DW-1:0] div_cnt_q;
    logic [DW-1:0] div_cnt_d;

    always_comb begin
        tick      = en && (div_cnt_q == DIV_LAST);
        div_cnt_d = div_cnt_q;
        if (tick) begin
            div_cnt_d = '0;
        end else if (en) begin
            div_cnt_d = div_cnt_q + DIV_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA raster timing: h/v counters, sync/active decode and registered strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter int CLK_DIV  = 2,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          p_tick,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CW < 1 || CW > 30 ||
        H_TOTAL > (2 ** CW) || V_TOTAL > (2 ** CW)) begin : g_param_error
        $error("vga_timing_gen: illegal timing parameters");
    end

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic          HS_ON    = (HS_POL != 0);
    localparam logic          VS_ON    = (VS_POL != 0);

    logic          tick;
    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          video_on_q, video_on_d;
    logic          p_tick_q, p_tick_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    pixel_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_pixel_tick_gen (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .tick (tick)
    );

    // Decode uses the next-state counts so levels and coordinates move on the same edge.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_ONE;
            end else begin
                h_cnt_d = h_cnt_q + CNT_ONE;
            end
        end

        hsync_d       = (h_cnt_d >= HS_START && h_cnt_d <= HS_END) ? HS_ON : ~HS_ON;
        vsync_d       = (v_cnt_d >= VS_START && v_cnt_d <= VS_END) ? VS_ON : ~VS_ON;
        video_on_d    = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
        p_tick_d      = tick;
        line_start_d  = tick && (h_cnt_d == '0);
        frame_start_d = line_start_d && (v_cnt_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= ~HS_ON;
            vsync_q       <= ~VS_ON;
            video_on_q    <= 1'b0;
            p_tick_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            p_tick_q      <= p_tick_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign p_tick      = p_tick_q;
    assign pixel_x     = h_cnt_q;
    assign pixel_y     = v_cnt_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing, a reduced CLK_DIV=2 raster and a tiny CLK_DIV=1 raster.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetA, enA, hsA, vsA, voA, ptA, lsA, fsA;
    logic [9:0] pxA, pyA;
    logic       resetB, enB, hsB, vsB, voB, ptB, lsB, fsB;
    logic [5:0] pxB, pyB;
    logic       resetC, enC, hsC, vsC, voC, ptC, lsC, fsC;
    logic [3:0] pxC, pyC;

    int checkCount = 0;
    int errorCount = 0;

    vga_timing_gen dutA (
        .clk(clk), .reset(resetA), .en(enA), .hsync(hsA), .vsync(vsA), .video_on(voA),
        .p_tick(ptA), .pixel_x(pxA), .pixel_y(pyA), .line_start(lsA), .frame_start(fsA)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(2), .HS_POL(0), .VS_POL(0), .CW(6)
    ) dutB (
        .clk(clk), .reset(resetB), .en(enB), .hsync(hsB), .vsync(vsB), .video_on(voB),
        .p_tick(ptB), .pixel_x(pxB), .pixel_y(pyB), .line_start(lsB), .frame_start(fsB)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .HS_POL(1), .VS_POL(1), .CW(4)
    ) dutC (
        .clk(clk), .reset(resetC), .en(enC), .hsync(hsC), .vsync(vsC), .video_on(voC),
        .p_tick(ptC), .pixel_x(pxC), .pixel_y(pyC), .line_start(lsC), .frame_start(fsC)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic rstVal, input logic enVal);
        case (sel)
            0: begin resetA = rstVal; enA = enVal; end
            1: begin resetB = rstVal; enB = enVal; end
            default: begin resetC = rstVal; enC = enVal; end
        endcase
    endtask

    int prevX, prevY, hsLow, hsFirst, hsLast, vsLow, vsFirst, vsLast;
    int seqErr, voErr, holdErr, sawWrap, found, fsAt, lastLs, hsHigh, vsHigh;

    initial begin
        applyStimulus(0, 1'b1, 1'b0);
        applyStimulus(1, 1'b1, 1'b0);
        applyStimulus(2, 1'b1, 1'b0);
        #2;
        checkOutput("A_rst_hsync", hsA, 1);
        checkOutput("A_rst_vsync", vsA, 1);
        checkOutput("A_rst_video_on", voA, 0);
        checkOutput("A_rst_p_tick", ptA, 0);
        checkOutput("A_rst_x", pxA, 0);
        checkOutput("A_rst_y", pyA, 0);
        checkOutput("A_rst_line_start", lsA, 0);
        checkOutput("A_rst_frame_start", fsA, 0);
        checkOutput("C_rst_hsync", hsC, 0);
        checkOutput("C_rst_vsync", vsC, 0);

        // Default raster: first edge, then a full line 0 scan through the x wrap.
        @(negedge clk);
        applyStimulus(0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("A_first_video_on", voA, 1);
        checkOutput("A_first_x", pxA, 0);
        checkOutput("A_first_p_tick", ptA, 0);
        checkOutput("A_first_frame_start", fsA, 0);

        prevX = 0; hsLow = 0; hsFirst = -1; hsLast = -1; seqErr = 0; voErr = 0; sawWrap = 0;
        for (int i = 0; i < 1700 && sawWrap == 0; i++) begin
            @(negedge clk);
            if (hsA == 1'b0) begin
                hsLow++;
                if (hsFirst < 0) hsFirst = int'(pxA);
                hsLast = int'(pxA);
            end
            if (voA !== ((pxA < 640) && (pyA < 480))) voErr++;
            if (int'(pxA) != prevX) begin
                if (ptA !== 1'b1) seqErr++;
                if (pxA == 0) begin
                    sawWrap = 1;
                    checkOutput("A_wrap_prev_x", prevX, 799);
                    checkOutput("A_wrap_line_start", lsA, 1);
                    checkOutput("A_wrap_y", pyA, 1);
                    checkOutput("A_wrap_frame_start", fsA, 0);
                end else if (int'(pxA) != prevX + 1) begin
                    seqErr++;
                end
            end else if (ptA !== 1'b0) begin
                seqErr++;
            end
            if (lsA && pxA != 0) seqErr++;
            prevX = int'(pxA);
        end
        checkOutput("A_line_wrap_seen", sawWrap, 1);
        checkOutput("A_hsync_low_clks", hsLow, 192);
        checkOutput("A_hsync_first_x", hsFirst, 656);
        checkOutput("A_hsync_last_x", hsLast, 751);
        checkOutput("A_video_on_errors", voErr, 0);
        checkOutput("A_sequence_errors", seqErr, 0);

        // Freeze at (100,20) on the first clk of that pixel, then resume.
        found = 0;
        for (int i = 0; i < 40000 && found == 0; i++) begin
            @(negedge clk);
            if (pxA == 100 && pyA == 20 && ptA) found = 1;
        end
        checkOutput("A_reach_100_20", found, 1);
        if (found == 1) begin
            applyStimulus(0, 1'b0, 1'b0);
            holdErr = 0;
            for (int i = 0; i < 37; i++) begin
                @(negedge clk);
                if (pxA !== 10'd100 || pyA !== 10'd20 || ptA !== 1'b0 || lsA !== 1'b0 ||
                    fsA !== 1'b0 || hsA !== 1'b1 || vsA !== 1'b1 || voA !== 1'b1) holdErr++;
            end
            checkOutput("A_hold_errors", holdErr, 0);
            applyStimulus(0, 1'b0, 1'b1);
            @(negedge clk);
            checkOutput("A_resume1_x", pxA, 100);
            checkOutput("A_resume1_p_tick", ptA, 0);
            @(negedge clk);
            checkOutput("A_resume2_x", pxA, 101);
            checkOutput("A_resume2_p_tick", ptA, 1);
            @(negedge clk);
            checkOutput("A_resume3_x", pxA, 101);
            @(negedge clk);
            checkOutput("A_resume4_x", pxA, 102);
            checkOutput("A_resume4_y", pyA, 20);
        end
        applyStimulus(0, 1'b0, 1'b0);

        // Reduced raster, 23x17 at CLK_DIV=2: frame is 782 clks.
        applyStimulus(1, 1'b0, 1'b1);
        prevX = 0; prevY = 0; fsAt = -1; hsLow = 0; vsLow = 0; vsFirst = -1; vsLast = -1;
        for (int n = 1; n <= 1000 && fsAt < 0; n++) begin
            @(negedge clk);
            if (hsB == 1'b0) hsLow++;
            if (vsB == 1'b0) begin
                vsLow++;
                if (vsFirst < 0) vsFirst = int'(pyB);
                vsLast = int'(pyB);
            end
            if (fsB) begin
                fsAt = n;
                checkOutput("B_wrap_prev_x", prevX, 22);
                checkOutput("B_wrap_prev_y", prevY, 16);
                checkOutput("B_wrap_x", pxB, 0);
                checkOutput("B_wrap_y", pyB, 0);
                checkOutput("B_wrap_line_start", lsB, 1);
            end
            prevX = int'(pxB);
            prevY = int'(pyB);
        end
        checkOutput("B_first_frame_clks", fsAt, 782);
        checkOutput("B_hsync_low_clks", hsLow, 102);
        checkOutput("B_vsync_low_clks", vsLow, 92);
        checkOutput("B_vsync_first_y", vsFirst, 12);
        checkOutput("B_vsync_last_y", vsLast, 13);
        fsAt = -1;
        for (int n = 1; n <= 1000 && fsAt < 0; n++) begin
            @(negedge clk);
            if (fsB) fsAt = n;
        end
        checkOutput("B_frame_period", fsAt, 782);

        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            @(negedge clk);
            if (pxB == 20 && pyB == 12) found = 1;
        end
        checkOutput("B_reach_20_12", found, 1);
        checkOutput("B_pre_reset_hsync", hsB, 0);
        checkOutput("B_pre_reset_vsync", vsB, 0);
        applyStimulus(1, 1'b1, 1'b1);
        #1;
        checkOutput("B_async_hsync", hsB, 1);
        checkOutput("B_async_vsync", vsB, 1);
        checkOutput("B_async_video_on", voB, 0);
        checkOutput("B_async_x", pxB, 0);
        checkOutput("B_async_y", pyB, 0);
        checkOutput("B_async_p_tick", ptB, 0);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(1, 1'b0, 1'b1);
        fsAt = -1;
        for (int n = 1; n <= 1000 && fsAt < 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                checkOutput("B_restart_x", pxB, 0);
                checkOutput("B_restart_y", pyB, 0);
                checkOutput("B_restart_video_on", voB, 1);
            end
            if (fsB) fsAt = n;
        end
        checkOutput("B_restart_frame_clks", fsAt, 782);
        applyStimulus(1, 1'b0, 1'b0);

        // Tiny raster, 8x6 at CLK_DIV=1 with active-high syncs, two full frames.
        applyStimulus(2, 1'b0, 1'b1);
        prevX = 0; prevY = 0; seqErr = 0; lastLs = -1; hsHigh = 0; vsHigh = 0; voErr = 0;
        for (int n = 1; n <= 96; n++) begin
            @(negedge clk);
            if (n == 1) checkOutput("C_first_x", pxC, 1);
            if (ptC !== 1'b1) seqErr++;
            if (hsC) hsHigh++;
            if (vsC) vsHigh++;
            if (hsC !== (pxC >= 5 && pxC <= 6)) seqErr++;
            if (vsC !== (pyC == 4)) seqErr++;
            if (voC !== (pxC < 4 && pyC < 3)) voErr++;
            if (lsC !== (pxC == 0)) seqErr++;
            if (fsC !== (pxC == 0 && pyC == 0)) seqErr++;
            if (int'(pxC) != (prevX + 1) % 8) seqErr++;
            if (pxC == 0) begin
                if (int'(pyC) != (prevY + 1) % 6) seqErr++;
            end else if (int'(pyC) != prevY) begin
                seqErr++;
            end
            if (lsC) begin
                if (lastLs >= 0 && n - lastLs != 8) seqErr++;
                lastLs = n;
            end
            prevX = int'(pxC);
            prevY = int'(pyC);
        end
        checkOutput("C_hsync_high_clks", hsHigh, 24);
        checkOutput("C_vsync_high_clks", vsHigh, 16);
        checkOutput("C_video_on_errors", voErr, 0);
        checkOutput("C_sequence_errors", seqErr, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
